// File: rtl/tx_symbol_pacer_if.sv
// rtl/tx_symbol_pacer_if.sv - PHY type package and bit/sample stream interface for tx_symbol_pacer
package tx_symbol_pacer_pkg;
  typedef enum logic [1:0] {
    PHY_1M    = 2'd0,
    PHY_2M    = 2'd1,
    PHY_CODED = 2'd2
  } ble_phy_t;
endpackage

interface tx_symbol_pacer_if;
  logic       input_tdata;
  logic       input_tvalid;
  logic       input_tready;
  logic       input_tlast;
  logic [1:0] output_tdata;
  logic       output_tvalid;

  // master: packet bit source and shaping-filter sink; slave: the pacer
  modport master (
    output input_tdata, input_tvalid, input_tlast,
    input  input_tready, output_tdata, output_tvalid
  );
  modport slave (
    input  input_tdata, input_tvalid, input_tlast,
    output input_tready, output_tdata, output_tvalid
  );
endinterface

// File: rtl/tx_symbol_pacer.sv
// rtl/tx_symbol_pacer.sv - paces a 1-bit packet stream onto the sample grid as NRZ levels; TX_PACER_SYM_COUNT_EN adds symbol_count
module tx_symbol_pacer
  import tx_symbol_pacer_pkg::*;
#(
  parameter int SPS      = 8,
  parameter int RAMP_LEN = 16
) (
  input  logic     aclk,
  input  logic     aresetn,
  input  logic     task_start,
  input  logic     task_stop,
  input  ble_phy_t phy_type,
  input  logic     sample_strobe,
  tx_symbol_pacer_if.slave bus,
  output logic     tx_en,
  output logic     event_end,
  output logic     underrun
`ifdef TX_PACER_SYM_COUNT_EN
  ,
  output logic [15:0] symbol_count
`endif
);

  localparam int SW = $clog2(SPS);
  localparam int RW = $clog2(RAMP_LEN + 1);
  localparam logic [SW-1:0] CNT_LAST_FULL = SW'(SPS - 1);
  localparam logic [SW-1:0] CNT_LAST_HALF = SW'(SPS / 2 - 1);
  localparam logic [RW-1:0] RAMP_LAST     = RW'(RAMP_LEN - 1);
  localparam logic [1:0] LVL_POS  = 2'b01;
  localparam logic [1:0] LVL_NEG  = 2'b11;
  localparam logic [1:0] LVL_ZERO = 2'b00;

  typedef enum logic [1:0] {IDLE, RAMP_UP, DATA, RAMP_DOWN} state_t;

  state_t          state_q, state_d;
  logic            next_bit_q, next_bit_d;
  logic            next_last_q, next_last_d;
  logic            next_valid_q, next_valid_d;
  logic            cur_bit_q, cur_bit_d;
  logic            cur_last_q, cur_last_d;
  logic            last_seen_q, last_seen_d;
  logic            half_rate_q, half_rate_d;
  logic            tx_en_q, tx_en_d;
  logic            underrun_q, underrun_d;
  logic            event_end_q, event_end_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      out_data_q, out_data_d;
  logic [SW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [RW-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [SW-1:0]   sym_last;
  logic            accept;
  logic            load_sym;
`ifdef TX_PACER_SYM_COUNT_EN
  logic [15:0]     sym_cnt_q, sym_cnt_d;
`endif

  // A beat is taken only while the holding register is empty and the packet is still being fed
  assign bus.input_tready = ~next_valid_q && ((state_q == RAMP_UP) || (state_q == DATA)) && ~last_seen_q;
  assign accept           = bus.input_tvalid && bus.input_tready;
  assign sym_last         = half_rate_q ? CNT_LAST_HALF : CNT_LAST_FULL;

  assign bus.output_tdata  = out_data_q;
  assign bus.output_tvalid = out_valid_q;
  assign tx_en             = tx_en_q;
  assign event_end         = event_end_q;
  assign underrun          = underrun_q;
`ifdef TX_PACER_SYM_COUNT_EN
  assign symbol_count      = sym_cnt_q;
`endif

  // Next-state, holding register and registered-output computation
  always_comb begin
    state_d      = state_q;
    next_bit_d   = next_bit_q;
    next_last_d  = next_last_q;
    next_valid_d = next_valid_q;
    cur_bit_d    = cur_bit_q;
    cur_last_d   = cur_last_q;
    last_seen_d  = last_seen_q;
    half_rate_d  = half_rate_q;
    tx_en_d      = tx_en_q;
    underrun_d   = underrun_q;
    event_end_d  = 1'b0;
    out_valid_d  = 1'b0;
    out_data_d   = LVL_ZERO;
    sample_cnt_d = sample_cnt_q;
    ramp_cnt_d   = ramp_cnt_q;
    load_sym     = 1'b0;
`ifdef TX_PACER_SYM_COUNT_EN
    sym_cnt_d    = sym_cnt_q;
`endif

    if (accept) begin
      next_valid_d = 1'b1;
      next_bit_d   = bus.input_tdata;
      next_last_d  = bus.input_tlast;
      if (bus.input_tlast) last_seen_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (task_start) begin
          state_d     = RAMP_UP;
          tx_en_d     = 1'b1;
          underrun_d  = 1'b0;
          last_seen_d = 1'b0;
          ramp_cnt_d  = '0;
          half_rate_d = (phy_type == PHY_2M);
`ifdef TX_PACER_SYM_COUNT_EN
          sym_cnt_d   = '0;
`endif
        end
      end
      RAMP_UP: begin
        if (task_stop) begin
          state_d      = RAMP_DOWN;
          ramp_cnt_d   = '0;
          next_valid_d = 1'b0;
          out_valid_d  = sample_strobe;
        end else if (sample_strobe) begin
          out_valid_d = 1'b1;
          if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = '0;
            if (next_valid_q) begin
              state_d  = DATA;
              load_sym = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = RAMP_DOWN;
            end
          end else begin
            ramp_cnt_d = ramp_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (task_stop) begin
          state_d      = RAMP_DOWN;
          ramp_cnt_d   = '0;
          next_valid_d = 1'b0;
          out_valid_d  = sample_strobe;
        end else if (sample_strobe) begin
          out_valid_d = 1'b1;
          out_data_d  = cur_bit_q ? LVL_POS : LVL_NEG;
          if (sample_cnt_q == sym_last) begin
            if (cur_last_q) begin
              state_d    = RAMP_DOWN;
              ramp_cnt_d = '0;
            end else if (next_valid_q) begin
              load_sym = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = RAMP_DOWN;
              ramp_cnt_d = '0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        if (sample_strobe) begin
          out_valid_d = 1'b1;
          if (ramp_cnt_q == RAMP_LAST) begin
            state_d      = IDLE;
            tx_en_d      = 1'b0;
            event_end_d  = 1'b1;
            next_valid_d = 1'b0;
            ramp_cnt_d   = '0;
            sample_cnt_d = '0;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered next bit becomes the current symbol; a beat accepted this cycle is not seen here
    if (load_sym) begin
      cur_bit_d    = next_bit_q;
      cur_last_d   = next_last_q;
      next_valid_d = 1'b0;
      sample_cnt_d = '0;
`ifdef TX_PACER_SYM_COUNT_EN
      if (sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
`endif
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      next_bit_q   <= 1'b0;
      next_last_q  <= 1'b0;
      next_valid_q <= 1'b0;
      cur_bit_q    <= 1'b0;
      cur_last_q   <= 1'b0;
      last_seen_q  <= 1'b0;
      half_rate_q  <= 1'b0;
      tx_en_q      <= 1'b0;
      underrun_q   <= 1'b0;
      event_end_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= LVL_ZERO;
      sample_cnt_q <= '0;
      ramp_cnt_q   <= '0;
`ifdef TX_PACER_SYM_COUNT_EN
      sym_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      next_bit_q   <= next_bit_d;
      next_last_q  <= next_last_d;
      next_valid_q <= next_valid_d;
      cur_bit_q    <= cur_bit_d;
      cur_last_q   <= cur_last_d;
      last_seen_q  <= last_seen_d;
      half_rate_q  <= half_rate_d;
      tx_en_q      <= tx_en_d;
      underrun_q   <= underrun_d;
      event_end_q  <= event_end_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sample_cnt_q <= sample_cnt_d;
      ramp_cnt_q   <= ramp_cnt_d;
`ifdef TX_PACER_SYM_COUNT_EN
      sym_cnt_q    <= sym_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_symbol_pacer.sv
// tb/tb_tx_symbol_pacer.sv - self-checking bench for tx_symbol_pacer
module tb_tx_symbol_pacer;
  import tx_symbol_pacer_pkg::*;

  localparam int SPS      = 8;
  localparam int RAMP_LEN = 16;

  logic     aclk = 1'b0;
  logic     aresetn = 1'b0;
  logic     task_start = 1'b0;
  logic     task_stop = 1'b0;
  logic     sample_strobe = 1'b0;
  ble_phy_t phy_type = PHY_1M;
  logic     tx_en, event_end, underrun;
`ifdef TX_PACER_SYM_COUNT_EN
  logic [15:0] symbol_count;
`endif

  tx_symbol_pacer_if bus();

  always #5 aclk = ~aclk;

  tx_symbol_pacer #(.SPS(SPS), .RAMP_LEN(RAMP_LEN)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .task_start    (task_start),
    .task_stop     (task_stop),
    .phy_type      (phy_type),
    .sample_strobe (sample_strobe),
    .bus           (bus),
    .tx_en         (tx_en),
    .event_end     (event_end),
    .underrun      (underrun)
`ifdef TX_PACER_SYM_COUNT_EN
    ,
    .symbol_count  (symbol_count)
`endif
  );

  typedef struct {
    ble_phy_t    phy;
    int          nbits;
    logic [15:0] bits;          // bits[0] is sent first
    int          hold_idx;      // beat index the source withholds (-1: none)
    int          hold_samples;  // withheld until this many samples were seen
    int          stop_sample;   // task_stop after this sample (0: none)
    bit          chk_ready;
    int          exp_samples;
    logic        exp_underrun;
    int          exp_accepted;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [1:0] q[$];
    int  p, emitted, ndata, idx, seen, accepted, txen_bad, ready_bad;
    bit  hold_blocks, fire, done, stop_now;
    p = (v.phy == PHY_2M) ? SPS / 2 : SPS;
    hold_blocks = (v.hold_idx >= 0) && (v.hold_idx < v.nbits) &&
                  (v.hold_samples >= RAMP_LEN + v.hold_idx * p);
    emitted = hold_blocks ? v.hold_idx : v.nbits;
    ndata = emitted * p;
    if (v.stop_sample > 0 && v.stop_sample - RAMP_LEN < ndata) ndata = v.stop_sample - RAMP_LEN;
    for (int i = 0; i < RAMP_LEN; i++) q.push_back(2'b00);
    for (int i = 0; i < ndata; i++) q.push_back(v.bits[i / p] ? 2'b01 : 2'b11);
    for (int i = 0; i < RAMP_LEN; i++) q.push_back(2'b00);

    @(negedge aclk);
    phy_type = v.phy;
    task_start = 1'b1;
    @(negedge aclk);
    task_start = 1'b0;
    phy_type = PHY_1M;
    idx = 0; seen = 0; accepted = 0; txen_bad = 0; ready_bad = 0;
    fire = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      if (cyc > 0) @(negedge aclk);
      if (fire) begin idx++; accepted++; end
      stop_now = 1'b0;
      if (bus.output_tvalid) begin
        if (q.size() == 0) check($sformatf("v%0d_extra_sample", vi), 1, 0);
        else check($sformatf("v%0d_sample%0d", vi, seen), int'(bus.output_tdata), int'(q.pop_front()));
        seen++;
        if (!tx_en && !event_end) txen_bad++;
        if (v.stop_sample > 0 && seen == v.stop_sample) stop_now = 1'b1;
      end
      if (v.chk_ready && tx_en && seen < RAMP_LEN && !bus.input_tready) ready_bad++;
      if (event_end) begin
        done = 1'b1;
        check($sformatf("v%0d_end_with_last_sample", vi), int'(bus.output_tvalid), 1);
      end
      task_stop = stop_now;
      sample_strobe = (cyc % 4 == 0) && !done;
      bus.input_tvalid = (idx < v.nbits) && !(idx == v.hold_idx && seen < v.hold_samples);
      bus.input_tdata  = (idx < 16) ? v.bits[idx] : 1'b0;
      bus.input_tlast  = (idx == v.nbits - 1);
      fire = bus.input_tvalid && bus.input_tready;
    end
    task_stop = 1'b0;
    sample_strobe = 1'b0;
    bus.input_tvalid = 1'b0;
    bus.input_tlast = 1'b0;
    check($sformatf("v%0d_event_end_seen", vi), int'(done), 1);
    check($sformatf("v%0d_sample_count", vi), seen, v.exp_samples);
    check($sformatf("v%0d_queue_left", vi), q.size(), 0);
    check($sformatf("v%0d_underrun", vi), int'(underrun), int'(v.exp_underrun));
    check($sformatf("v%0d_accepted", vi), accepted, v.exp_accepted);
    check($sformatf("v%0d_tx_en_gap", vi), txen_bad, 0);
    if (v.chk_ready) check($sformatf("v%0d_ready_in_ramp_up", vi), ready_bad, 0);
`ifdef TX_PACER_SYM_COUNT_EN
    check($sformatf("v%0d_symbol_count", vi), int'(symbol_count), (ndata + p - 1) / p);
`endif
    @(negedge aclk);
    check($sformatf("v%0d_event_end_pulse", vi), int'(event_end), 0);
    check($sformatf("v%0d_tx_en_off", vi), int'(tx_en), 0);
    if (!done) begin
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tx_en"}, int'(tx_en), 0);
    check({tag, "_event_end"}, int'(event_end), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
    check({tag, "_out_valid"}, int'(bus.output_tvalid), 0);
    check({tag, "_out_data"}, int'(bus.output_tdata), 0);
    check({tag, "_tready"}, int'(bus.input_tready), 0);
  endtask

  initial begin
    //            phy        n   bits                hold  hsmp  stop rdy exp  ur    acc
    vecs[0] = '{PHY_1M,    3,  16'b101,            -1,   0,    0,   0, 56, 1'b0, 3};
    vecs[1] = '{PHY_2M,    3,  16'b101,            -1,   0,    0,   0, 44, 1'b0, 3};
    vecs[2] = '{PHY_CODED, 4,  16'b0110,           -1,   0,    0,   0, 64, 1'b0, 4};
    vecs[3] = '{PHY_1M,    10, 16'b10_1100_1010,   -1,   0,    27,  0, 43, 1'b0, 3};
    vecs[4] = '{PHY_1M,    3,  16'b101,            1,    24,   0,   0, 40, 1'b1, 1};
    vecs[5] = '{PHY_1M,    3,  16'b101,            0,    1000, 0,   1, 32, 1'b1, 0};

    bus.input_tdata = 1'b0;
    bus.input_tvalid = 1'b0;
    bus.input_tlast = 1'b0;
    repeat (3) @(negedge aclk);
    check_quiet("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
      repeat (2) @(negedge aclk);
    end

    // Reset asserted while the pacer is emitting data symbols
    phy_type = PHY_1M;
    task_start = 1'b1;
    @(negedge aclk);
    task_start = 1'b0;
    bus.input_tvalid = 1'b1;
    bus.input_tdata = 1'b1;
    bus.input_tlast = 1'b0;
    for (int c = 0; c < 100; c++) begin
      sample_strobe = (c % 4 == 0);
      @(negedge aclk);
    end
    sample_strobe = 1'b0;
    check("mid_packet_tx_en", int'(tx_en), 1);
    aresetn = 1'b0;
    #1;
    check_quiet("mid_reset");
`ifdef TX_PACER_SYM_COUNT_EN
    check("mid_reset_symbol_count", int'(symbol_count), 0);
`endif
    bus.input_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    run_vec(6, vecs[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
